// File: rtl/telem_readout.sv
// telem_readout: read-side sequencer for the telemetry target register file.
// On a start command it reads one target record (or sweeps every target) and
// serializes each record as a byte frame on a valid/ready stream.
// Optional build macro TELEM_CHECKSUM_EN appends an XOR checksum byte per frame.
//
// Stream handshake: a byte moves when tx_valid && tx_ready are both high at a
// rising clk edge. While tx_valid=1 and tx_ready=0, tx_data and tx_last are held
// stable, and tx_valid only drops without a transfer on abort or rst.
module telem_readout #(
  parameter int         NUM_TARGETS = 16,
  parameter int         IDX_W       = 4,
  parameter int         COORD_W     = 8,
  parameter logic [3:0] HDR_TAG     = 4'hA
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode_all,
  input  logic [IDX_W-1:0]   target_sel,
  input  logic               abort,
  output logic               busy,
  output logic               rd_en,
  output logic [IDX_W-1:0]   rd_addr,
  input  logic [COORD_W-1:0] rd_x,
  input  logic [COORD_W-1:0] rd_y,
  input  logic [COORD_W-1:0] rd_z,
  input  logic [COORD_W-1:0] rd_t,
  output logic [COORD_W-1:0] tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_last,
  output logic               done,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_CAP  = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

`ifdef TELEM_CHECKSUM_EN
  localparam logic [2:0] LAST_BYTE = 3'd5;
`else
  localparam logic [2:0] LAST_BYTE = 3'd4;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TARGETS - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic               mode_all_q, mode_all_d;
  logic [2:0]         byte_cnt_q, byte_cnt_d;
  logic [COORD_W-1:0] rec_x_q, rec_x_d;
  logic [COORD_W-1:0] rec_y_q, rec_y_d;
  logic [COORD_W-1:0] rec_z_q, rec_z_d;
  logic [COORD_W-1:0] rec_t_q, rec_t_d;
  logic [COORD_W-1:0] frame_byte;
`ifdef TELEM_CHECKSUM_EN
  logic [COORD_W-1:0] csum_q, csum_d;
`endif

  // Select the frame byte addressed by the byte counter.
  always_comb begin
    frame_byte = '0;
    case (byte_cnt_q)
      3'd0:    frame_byte = COORD_W'({HDR_TAG, index_q});
      3'd1:    frame_byte = rec_x_q;
      3'd2:    frame_byte = rec_y_q;
      3'd3:    frame_byte = rec_z_q;
      3'd4:    frame_byte = rec_t_q;
`ifdef TELEM_CHECKSUM_EN
      3'd5:    frame_byte = csum_q;
`endif
      default: frame_byte = '0;
    endcase
  end

  // Next-state and datapath updates; abort overrides every non-idle state.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    mode_all_d = mode_all_q;
    byte_cnt_d = byte_cnt_q;
    rec_x_d    = rec_x_q;
    rec_y_d    = rec_y_q;
    rec_z_d    = rec_z_q;
    rec_t_d    = rec_t_q;
`ifdef TELEM_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        // abort in the same cycle drops the start
        if (start && !abort) begin
          mode_all_d = mode_all;
          index_d    = mode_all ? '0 : target_sel;
          state_d    = S_REQ;
        end
      end
      S_REQ: state_d = S_CAP;
      S_CAP: begin
        // read data is valid exactly one cycle after the request
        rec_x_d    = rd_x;
        rec_y_d    = rd_y;
        rec_z_d    = rd_z;
        rec_t_d    = rd_t;
        byte_cnt_d = '0;
`ifdef TELEM_CHECKSUM_EN
        csum_d     = '0;
`endif
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (tx_ready) begin
`ifdef TELEM_CHECKSUM_EN
          csum_d = csum_q ^ frame_byte;
`endif
          if (byte_cnt_q == LAST_BYTE) begin
            if (mode_all_q && (index_q < LAST_IDX)) begin
              index_d = index_q + IDX_W'(1);
              state_d = S_REQ;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      index_q    <= '0;
      mode_all_q <= 1'b0;
      byte_cnt_q <= '0;
      rec_x_q    <= '0;
      rec_y_q    <= '0;
      rec_z_q    <= '0;
      rec_t_q    <= '0;
`ifdef TELEM_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      mode_all_q <= mode_all_d;
      byte_cnt_q <= byte_cnt_d;
      rec_x_q    <= rec_x_d;
      rec_y_q    <= rec_y_d;
      rec_z_q    <= rec_z_d;
      rec_t_q    <= rec_t_d;
`ifdef TELEM_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign rd_en     = (state_q == S_REQ);
  assign rd_addr   = index_q;
  assign tx_valid  = (state_q == S_SEND);
  assign tx_data   = (state_q == S_SEND) ? frame_byte : '0;
  assign tx_last   = (state_q == S_SEND) && (byte_cnt_q == LAST_BYTE);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_telem_readout.sv
// tb_telem_readout: randomized and directed bench for telem_readout with a
// frame-level reference model and an expected-byte scoreboard.
module tb_telem_readout;

`ifdef TELEM_CHECKSUM_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic       mode_all = 1'b0;
  logic [3:0] target_sel = '0;
  logic       abort = 1'b0;
  logic       tx_ready = 1'b1;
  logic       busy, rd_en, tx_valid, tx_last, done;
  logic [3:0] rd_addr;
  logic [7:0] rd_x, rd_y, rd_z, rd_t, tx_data;
  logic [2:0] dbg_state;

  telem_readout dut (
    .clk(clk), .rst(rst), .start(start), .mode_all(mode_all),
    .target_sel(target_sel), .abort(abort), .busy(busy), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_x(rd_x), .rd_y(rd_y), .rd_z(rd_z), .rd_t(rd_t),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_last(tx_last), .done(done), .dbg_state(dbg_state)
  );

  // Target storage model: answers one cycle after rd_en, garbage otherwise.
  logic [7:0] mem_x[16], mem_y[16], mem_z[16], mem_t[16];
  always @(posedge clk) begin
    if (rd_en) begin
      rd_x <= mem_x[rd_addr]; rd_y <= mem_y[rd_addr];
      rd_z <= mem_z[rd_addr]; rd_t <= mem_t[rd_addr];
    end else begin
      rd_x <= 8'($urandom); rd_y <= 8'($urandom);
      rd_z <= 8'($urandom); rd_t <= 8'($urandom);
    end
  end

  // Sink ready: forced level or random backpressure.
  logic rand_ready = 1'b0;
  logic ready_force = 1'b1;
  always @(posedge clk) begin
    #1;
    tx_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [8:0] exp_q[$];       // {last, byte}
  logic [3:0] exp_addr_q[$];
  int done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: one frame = header, X, Y, Z, T (+ XOR of those).
  task automatic push_frame(input logic [3:0] idx);
    logic [7:0] b[6];
    b[0] = {4'hA, idx};
    b[1] = mem_x[idx]; b[2] = mem_y[idx]; b[3] = mem_z[idx]; b[4] = mem_t[idx];
    b[5] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4];
    exp_addr_q.push_back(idx);
    for (int k = 0; k < NB; k++) exp_q.push_back({(k == NB - 1), b[k]});
  endtask

  // Monitor: transfers, read requests, stall stability, done pulses.
  logic       mon_en = 1'b0;
  logic       prev_stall = 1'b0, prev_kill = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = '0;
  logic [8:0] e;
  logic [3:0] ea;
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (prev_stall && !prev_kill) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, prev_data);
        check("hold_last", tx_last, prev_last);
      end
      if (tx_valid && tx_ready) begin
        check("byte_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("tx_data", tx_data, e[7:0]);
          check("tx_last", tx_last, e[8]);
        end
      end
      if (rd_en) begin
        check("read_expected", (exp_addr_q.size() > 0), 1);
        if (exp_addr_q.size() > 0) begin
          ea = exp_addr_q.pop_front();
          check("rd_addr", rd_addr, ea);
        end
      end
      if (done) done_cnt++;
    end
    prev_stall = tx_valid && !tx_ready;
    prev_kill  = abort || rst;
    prev_data  = tx_data;
    prev_last  = tx_last;
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic m, input logic [3:0] t);
    @(posedge clk); #1;
    start = 1'b1; mode_all = m; target_sel = t;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_bytes_left"}, exp_q.size(), 0);
    check({tag, "_reads_left"}, exp_addr_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  int n, d0;
  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_x[i] = 8'(i); mem_y[i] = 8'(i); mem_z[i] = 8'(i); mem_t[i] = 8'(i);
    end

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_reset("reset");
    check("reset_rd_addr", rd_addr, 0);
    check("reset_tx_data", tx_data, 0);
    check("reset_tx_last", tx_last, 0);
    @(posedge clk); #1 rst = 1'b0;
    mon_en = 1'b1;

    // single read, ready stuck high, with latency checks
    mem_x[11] = 8'h55; mem_y[11] = 8'hF0; mem_z[11] = 8'hAA; mem_t[11] = 8'hCC;
    push_frame(4'd11);
    do_start(1'b0, 4'd11);
    @(negedge clk);
    check("req_rd_en", rd_en, 1);
    check("req_rd_addr", rd_addr, 11);
    check("req_busy", busy, 1);
    check("req_tx_valid", tx_valid, 0);
    @(negedge clk);
    check("cap_rd_en", rd_en, 0);
    check("cap_tx_valid", tx_valid, 0);
    @(negedge clk);
    check("first_valid", tx_valid, 1);
    check("first_byte", tx_data, 8'hAB);
    wait_done(50, n);
    check("single_len", n, NB);
    check("done_cycle_busy", busy, 1);
    @(negedge clk);
    check("done_width", done, 0);
    check("busy_after_done", busy, 0);
    check_drained("single");

    // start on the DONE cycle is ignored
    push_frame(4'd11);
    do_start(1'b0, 4'd11);
    repeat (2 + NB) @(posedge clk);
    #1 start = 1'b1; target_sel = 4'd7;
    @(negedge clk);
    check("done_cycle_done", done, 1);
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    check("start_on_done_busy", busy, 0);
    check_drained("start_on_done");

    // backpressure: ready low for 3 cycles at byte 2
    push_frame(4'd11);
    do_start(1'b0, 4'd11);
    repeat (4) @(posedge clk);
    ready_force = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("stall_valid", tx_valid, 1);
      check("stall_data", tx_data, 8'hF0);
    end
    @(posedge clk);
    ready_force = 1'b1;
    wait_done(50, n);
    @(negedge clk);
    check_drained("backpressure");

    // full sweep with a start pulse while busy
    for (int i = 0; i < 16; i++) begin
      mem_x[i] = 8'(i); mem_y[i] = 8'(i); mem_z[i] = 8'(i); mem_t[i] = 8'(i);
      push_frame(4'(i));
    end
    d0 = done_cnt;
    do_start(1'b1, 4'd9);
    repeat (20) @(posedge clk);
    #1 start = 1'b1; mode_all = 1'b0; target_sel = 4'd3;
    @(posedge clk); #1 start = 1'b0;
    wait_done(2000, n);
    check("sweep_cycles", n, 16 * (2 + NB) - 20);
    repeat (4) @(negedge clk);
    check("sweep_done_pulses", done_cnt - d0, 1);
    check("sweep_idle", busy, 0);
    check_drained("sweep");

    // abort at byte 2 of target 5
    mem_x[5] = 8'($urandom); mem_y[5] = 8'($urandom);
    mem_z[5] = 8'($urandom); mem_t[5] = 8'($urandom);
    for (int r = 0; r < 2; r++) begin
      push_frame(4'd5);
      d0 = done_cnt;
      do_start(1'b0, 4'd5);
      repeat (4) @(posedge clk);
      ready_force = 1'b0;
      #1;
      if (r == 0) abort = 1'b1; else rst = 1'b1;
      @(posedge clk);
      ready_force = 1'b1;
      #1 abort = 1'b0; rst = 1'b0;
      @(negedge clk);
      check_idle_reset(r == 0 ? "abort" : "rst");
      if (r == 1) begin
        check("rst_rd_addr", rd_addr, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_last", tx_last, 0);
      end
      exp_q.delete();
      exp_addr_q.delete();
      repeat (3) @(negedge clk);
      check("kill_no_done", done_cnt - d0, 0);
      // clean frame afterwards
      push_frame(4'd5);
      do_start(1'b0, 4'd5);
      wait_done(50, n);
      @(negedge clk);
      check_drained("after_kill");
    end

    // randomized commands with random backpressure
    rand_ready = 1'b1;
    for (int it = 0; it < 8; it++) begin
      logic       m;
      logic [3:0] t;
      for (int i = 0; i < 16; i++) begin
        mem_x[i] = 8'($urandom); mem_y[i] = 8'($urandom);
        mem_z[i] = 8'($urandom); mem_t[i] = 8'($urandom);
      end
      m = ($urandom_range(0, 3) == 0);
      t = 4'($urandom_range(0, 15));
      if (m) for (int i = 0; i < 16; i++) push_frame(4'(i));
      else push_frame(t);
      d0 = done_cnt;
      do_start(m, t);
      wait_done(3000, n);
      repeat (2) @(negedge clk);
      check("rand_done_pulses", done_cnt - d0, 1);
      check_drained("rand");
    end
    rand_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
